// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - mode encodings and BCD limits for the clock set controller
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_COMMIT  = 2'd3
  } mode_e;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] BCD_ZERO = 8'h00;

endpackage

// File: rtl/bcd2_wrap_inc.sv
// rtl/bcd2_wrap_inc.sv - combinational two-digit BCD +1 wrapping at MAX, invalid input goes to zero
module bcd2_wrap_inc
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic [7:0] val,
  output logic [7:0] val_inc
);

  logic valid;

  // BCD order matches hex order, so a plain compare against MAX is a decimal compare
  always_comb begin
    valid   = (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= MAX);
    val_inc = BCD_ZERO;
    if (valid && (val != MAX)) begin
      if (val[3:0] == 4'd9) begin
        val_inc = {val[7:4] + 4'd1, 4'd0};
      end else begin
        val_inc = {val[7:4], val[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - second tick prescaler and RUN/SET_HR/SET_MIN/COMMIT time-set sequencer
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV      = 50_000_000,
  parameter int BLINK_DIV     = 25_000_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int TIMEOUT_SEC   = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  output logic       sec_tick,
  output logic       load,
  output logic [7:0] load_hour,
  output logic [7:0] load_min,
  output logic [1:0] mode,
  output logic       disp_on
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam int TW = $clog2(TIMEOUT_SEC + 1);

  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);
  localparam logic [RW-1:0] RPT_DELAY   = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_PERIOD  = RW'(REPEAT_PERIOD);
  localparam logic [TW-1:0] TIMEOUT_END = TW'(TIMEOUT_SEC);

  mode_e         state, state_nxt;
  logic          mode_prev, inc_prev;
  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          blink_q;
  logic [RW-1:0] rpt_cnt;
  logic          rpt_armed, rpt_fast;
  logic [TW-1:0] timeout_cnt;
  logic [7:0]    shadow_hour, shadow_min;
  logic [7:0]    hour_inc, min_inc;

  logic mode_edge, inc_rise, inc_edge, in_set, presc_wrap;
  logic rpt_step, inc_step, timeout_hit, state_chg;

  assign mode_edge   = btn_mode & ~mode_prev;
  assign inc_rise    = btn_inc & ~inc_prev;
  assign inc_edge    = inc_rise & ~mode_edge;
  assign in_set      = (state == MODE_SET_HR) || (state == MODE_SET_MIN);
  assign presc_wrap  = (presc == PRESC_LAST);
  assign rpt_step    = rpt_armed & btn_inc & ~inc_rise &
                       (rpt_fast ? (rpt_cnt == RPT_PERIOD) : (rpt_cnt == RPT_DELAY));
  assign inc_step    = in_set & ~mode_edge & (inc_edge | rpt_step);
  assign timeout_hit = (timeout_cnt == TIMEOUT_END);
  assign state_chg   = (state_nxt != state);

  bcd2_wrap_inc #(.MAX(HOUR_MAX)) u_hour_inc (.val(shadow_hour), .val_inc(hour_inc));
  bcd2_wrap_inc #(.MAX(MIN_MAX))  u_min_inc  (.val(shadow_min),  .val_inc(min_inc));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MODE_RUN;
      mode_prev <= 1'b0;
      inc_prev  <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode_prev <= btn_mode;
      inc_prev  <= btn_inc;
    end
  end

  always_comb begin
    state_nxt = state;
    sec_tick  = 1'b0;
    load      = 1'b0;
    mode      = state;
    disp_on   = 1'b1;
    case (state)
      MODE_RUN: begin
        sec_tick = presc_wrap;
        if (mode_edge) state_nxt = MODE_SET_HR;
      end
      MODE_SET_HR: begin
        disp_on = blink_q;
        if (mode_edge) state_nxt = MODE_SET_MIN;
        else if (timeout_hit) state_nxt = MODE_RUN;
      end
      MODE_SET_MIN: begin
        disp_on = blink_q;
        if (mode_edge) state_nxt = MODE_COMMIT;
        else if (timeout_hit) state_nxt = MODE_RUN;
      end
      default: begin
        load      = 1'b1;
        state_nxt = MODE_RUN;
      end
    endcase
  end

  // Cleared during the COMMIT cycle so the first tick lands TICK_DIV cycles after load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if ((state == MODE_COMMIT) || presc_wrap) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (state_chg || !in_set) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // rpt_cnt holds the number of cycles since the edge (or since the last repeat step)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
      rpt_fast  <= 1'b0;
    end else if (state_chg || !btn_inc || mode_edge) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
      rpt_fast  <= 1'b0;
    end else if (inc_rise) begin
      rpt_cnt   <= RW'(1);
      rpt_armed <= 1'b1;
      rpt_fast  <= 1'b0;
    end else if (rpt_armed) begin
      if (rpt_step) begin
        rpt_cnt  <= RW'(1);
        rpt_fast <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_cnt <= '0;
    end else if (state_chg || !in_set || mode_edge || inc_rise || rpt_step) begin
      timeout_cnt <= '0;
    end else if (presc_wrap) begin
      timeout_cnt <= timeout_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_hour <= BCD_ZERO;
      shadow_min  <= BCD_ZERO;
    end else if ((state == MODE_RUN) && mode_edge) begin
      shadow_hour <= cur_hour;
      shadow_min  <= cur_min;
    end else if (inc_step && (state == MODE_SET_HR)) begin
      shadow_hour <= hour_inc;
    end else if (inc_step && (state == MODE_SET_MIN)) begin
      shadow_min <= min_inc;
    end
  end

  assign load_hour = shadow_hour;
  assign load_min  = shadow_min;

endmodule
